// File: rtl/tdm_demux1x4.sv
// Receive end of a 4-slot TDM link: locks to the slot-0 sync marker and steers beats to out0..out3.
// Optional TDM_DEMUX_DOUBLE_BUFFER_EN: stage slots 0..2 in shadows so out0..out3 update as a coherent frame.
module tdm_demux1x4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             sel1,
  output logic             sel0,
  output logic             locked,
  output logic             frame_valid,
  output logic             sync_err
);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t           state_q;
  logic [1:0]       cnt_q;
  logic [1:0]       cnt_d;
  logic [WIDTH-1:0] out0_q, out1_q, out2_q, out3_q;
  logic             fv_q, err_q;
`ifdef TDM_DEMUX_DOUBLE_BUFFER_EN
  logic [WIDTH-1:0] sh0_q, sh1_q, sh2_q;
`endif

  assign cnt_d = cnt_q + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      cnt_q   <= 2'd0;
      out0_q  <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      out3_q  <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef TDM_DEMUX_DOUBLE_BUFFER_EN
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
`endif
    end else begin
      fv_q  <= 1'b0;
      err_q <= 1'b0;
      if (in_valid) begin
        case (state_q)
          HUNT: begin
            if (sync) begin
`ifdef TDM_DEMUX_DOUBLE_BUFFER_EN
              sh0_q <= in;
`else
              out0_q <= in;
`endif
              cnt_q   <= 2'd1;
              state_q <= LOCK;
            end
          end
          LOCK: begin
            if (sync) begin
              // A marker at slot 0 is the normal frame start; anywhere else it truncates the frame.
              if (cnt_q != 2'd0) err_q <= 1'b1;
`ifdef TDM_DEMUX_DOUBLE_BUFFER_EN
              sh0_q <= in;
              sh1_q <= '0;
              sh2_q <= '0;
`else
              out0_q <= in;
`endif
              cnt_q <= 2'd1;
            end else if (cnt_q == 2'd0) begin
              err_q   <= 1'b1;
              state_q <= HUNT;
`ifdef TDM_DEMUX_DOUBLE_BUFFER_EN
              sh0_q <= '0;
              sh1_q <= '0;
              sh2_q <= '0;
`endif
            end else begin
              case (cnt_q)
`ifdef TDM_DEMUX_DOUBLE_BUFFER_EN
                2'd1: sh1_q <= in;
                2'd2: sh2_q <= in;
                default: begin
                  out0_q <= sh0_q;
                  out1_q <= sh1_q;
                  out2_q <= sh2_q;
                  out3_q <= in;
                end
`else
                2'd1: out1_q <= in;
                2'd2: out2_q <= in;
                default: out3_q <= in;
`endif
              endcase
              if (cnt_q == 2'd3) fv_q <= 1'b1;
              cnt_q <= cnt_d;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign out0        = out0_q;
  assign out1        = out1_q;
  assign out2        = out2_q;
  assign out3        = out3_q;
  assign sel1        = cnt_q[1];
  assign sel0        = cnt_q[0];
  assign locked      = (state_q == LOCK);
  assign frame_valid = fv_q;
  assign sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux1x4.sv
// Randomized and directed bench for tdm_demux1x4 against a slot-index reference model.
module tb_tdm_demux1x4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in;
  logic         in_valid;
  logic         sync;
  logic [W-1:0] out0, out1, out2, out3;
  logic         sel1, sel0, locked, frame_valid, sync_err;

  int checks = 0;
  int failures = 0;

  // reference model state
  int           m_slot;
  bit           m_lock;
  bit           m_fv, m_err;
  logic [W-1:0] m_out[4];
  logic [W-1:0] m_sh[4];

  tdm_demux1x4 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .sync(sync),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .sel1(sel1), .sel0(sel0), .locked(locked),
    .frame_valid(frame_valid), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void m_put(input int k, input logic [W-1:0] d);
`ifdef TDM_DEMUX_DOUBLE_BUFFER_EN
    if (k < 3) m_sh[k] = d;
    else begin
      for (int i = 0; i < 3; i++) m_out[i] = m_sh[i];
      m_out[3] = d;
    end
`else
    m_out[k] = d;
`endif
  endfunction

  function automatic void m_step(input bit r, input bit v, input bit s, input logic [W-1:0] d);
    m_fv  = 1'b0;
    m_err = 1'b0;
    if (r) begin
      m_slot = 0;
      m_lock = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_out[i] = '0;
        m_sh[i]  = '0;
      end
    end else if (v) begin
      if (!m_lock) begin
        if (s) begin
          m_put(0, d);
          m_slot = 1;
          m_lock = 1'b1;
        end
      end else if (s) begin
        if (m_slot != 0) m_err = 1'b1;
        m_put(0, d);
        m_slot = 1;
      end else if (m_slot == 0) begin
        m_err  = 1'b1;
        m_lock = 1'b0;
      end else begin
        m_put(m_slot, d);
        if (m_slot == 3) m_fv = 1'b1;
        m_slot = (m_slot + 1) % 4;
      end
    end
  endfunction

  // Apply one beat, clock it, then compare every output against the model.
  task automatic cycle(input bit r, input bit v, input bit s, input logic [W-1:0] d);
    rst = r; in_valid = v; sync = s; in = d;
    @(posedge clk);
    m_step(r, v, s, d);
    #1;
    chk("out0", 32'(out0), 32'(m_out[0]));
    chk("out1", 32'(out1), 32'(m_out[1]));
    chk("out2", 32'(out2), 32'(m_out[2]));
    chk("out3", 32'(out3), 32'(m_out[3]));
    chk("sel", 32'({sel1, sel0}), 32'(m_slot));
    chk("locked", 32'(locked), 32'(m_lock));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("sync_err", 32'(sync_err), 32'(m_err));
    chk("fv_err_excl", 32'(frame_valid & sync_err), 32'd0);
  endtask

  task automatic frame(input logic [W-1:0] a, b, c, d);
    cycle(0, 1, 1, a);
    cycle(0, 1, 0, b);
    cycle(0, 1, 0, c);
    cycle(0, 1, 0, d);
  endtask

  int fv_count;

  initial begin
    rst = 1'b0; in = '0; in_valid = 1'b0; sync = 1'b0;
    m_slot = 0; m_lock = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_out[i] = '0;
      m_sh[i]  = '0;
    end
    @(negedge clk);

    // reset overrides an otherwise valid sync beat
    cycle(1, 1, 1, 4'h1);
    cycle(1, 1, 1, 4'h1);
    chk("rst_out", 32'({out0, out1, out2, out3}), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_sel", 32'({sel1, sel0}), 32'd0);

    // clean frame
    frame(4'h1, 4'h0, 4'h1, 4'h1);
    chk("clean_outs", 32'({out0, out1, out2, out3}), 32'h1011);
    chk("clean_fv", 32'(frame_valid), 32'd1);
    chk("clean_locked", 32'(locked), 32'd1);
    chk("clean_sel", 32'({sel1, sel0}), 32'd0);
    cycle(0, 0, 0, 4'h0);
    chk("clean_fv_one", 32'(frame_valid), 32'd0);

    // gapped frame with distinct data; outputs before the slot-3 edge depend on buffering
    fv_count = 0;
    cycle(0, 1, 1, 4'h5);
`ifdef TDM_DEMUX_DOUBLE_BUFFER_EN
    chk("buf_out0_hold", 32'(out0), 32'h1);
`else
    chk("direct_out0", 32'(out0), 32'h5);
`endif
    cycle(0, 1, 0, 4'h6);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 4'hF);
      chk("gap_sel", 32'({sel1, sel0}), 32'd2);
      fv_count += int'(frame_valid);
    end
    cycle(0, 1, 0, 4'h7);
    fv_count += int'(frame_valid);
    cycle(0, 1, 0, 4'h8);
    fv_count += int'(frame_valid);
    chk("gap_outs", 32'({out0, out1, out2, out3}), 32'h5678);
    chk("gap_fv_count", 32'(fv_count), 32'd1);

    // early sync after slots 0 and 1
    cycle(0, 1, 1, 4'h2);
    cycle(0, 1, 0, 4'h3);
    cycle(0, 1, 1, 4'h1);
    chk("early_err", 32'(sync_err), 32'd1);
    chk("early_sel", 32'({sel1, sel0}), 32'd1);
    chk("early_locked", 32'(locked), 32'd1);
    chk("early_fv", 32'(frame_valid), 32'd0);
`ifdef TDM_DEMUX_DOUBLE_BUFFER_EN
    chk("early_out0", 32'(out0), 32'h5);
`else
    chk("early_out0", 32'(out0), 32'h1);
`endif

    // missing sync after a complete frame
    cycle(0, 1, 0, 4'h0);
    cycle(0, 1, 0, 4'h0);
    cycle(0, 1, 0, 4'h9);
    frame(4'hA, 4'hB, 4'hC, 4'hD);
    cycle(0, 1, 0, 4'hE);
    chk("miss_err", 32'(sync_err), 32'd1);
    chk("miss_locked", 32'(locked), 32'd0);
    chk("miss_out0", 32'(out0), 32'hA);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 4'(i + 1));
    chk("miss_ignored", 32'({out0, out1, out2, out3}), 32'hABCD);
    chk("miss_still_hunt", 32'(locked), 32'd0);

    // randomized traffic with occasional mid-frame reset
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 4) == 0),
            4'($urandom));
    end
    // random well-formed frames so the frame path is heavily exercised
    for (int n = 0; n < 200; n++) begin
      frame(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 3) == 0) cycle(0, 0, 0, 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux1x4.md
Name: tdm_demux1x4

Overview:
- Sequential 1-to-4 time-division demultiplexer; the receive end of a 4-slot TDM link.
- A serial word stream is driven one slot per valid beat, with a sync marker on slot 0.
- This block locks to the marker, steers each beat to out0..out3, and flags completed frames and sync errors.
- Sits downstream of the 4:1 mux datapath and recovers the four original channels.

Parameters:
- WIDTH, 1, bit width of each slot word (in and out0..out3).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in  input  WIDTH  serial TDM data, sampled when in_valid=1.
- in_valid  input  1  beat qualifier; one slot is consumed per cycle with in_valid=1.
- sync  input  1  frame marker; meaningful only with in_valid=1; marks slot 0.
- out0  output  WIDTH  channel 0 (slot 0) data, registered.
- out1  output  WIDTH  channel 1 (slot 1) data, registered.
- out2  output  WIDTH  channel 2 (slot 2) data, registered.
- out3  output  WIDTH  channel 3 (slot 3) data, registered.
- sel1  output  1  MSB of the slot expected on the next beat.
- sel0  output  1  LSB of the slot expected on the next beat.
- locked  output  1  1 while in LOCK state.
- frame_valid  output  1  one-cycle pulse: slot 3 just captured, frame complete.
- sync_err  output  1  one-cycle pulse: sync protocol violation detected.

Behaviour:
- Reset: applies on the clk edge with rst=1 and overrides all other inputs.
  - out0..out3=0, slot counter=0 ({sel1,sel0}=00), state=HUNT.
  - locked=0, frame_valid=0, sync_err=0.
- State machine: two states, HUNT and LOCK, with a 2-bit slot counter. {sel1,sel0} always equals the counter.
- in_valid=0, any state: no state change; counter and outputs hold; frame_valid and sync_err are 0 next cycle.
- HUNT, in_valid=1, sync=0: beat discarded; stay in HUNT.
- HUNT, in_valid=1, sync=1: capture in as slot 0; counter->1; go to LOCK (locked=1 next cycle).
- LOCK, in_valid=1, sync=1, counter=0: capture slot 0; counter->1.
- LOCK, in_valid=1, sync=0, counter=1..3: capture into slot[counter].
  - Counter increments, wrapping 3->0.
  - When counter was 3, frame_valid=1 next cycle.
- LOCK, in_valid=1, sync=1, counter!=0 (early marker): resynchronise.
  - sync_err=1 next cycle.
  - Beat is treated as slot 0 (captured); counter->1; stay in LOCK.
  - No frame_valid for the truncated frame.
- LOCK, in_valid=1, sync=0, counter=0 (missing marker): lose lock.
  - sync_err=1 next cycle; beat discarded; go to HUNT; counter stays 0.
- Latency:
  - Captured data is visible on its outN one cycle after the capturing edge.
  - frame_valid asserts in the same cycle out3 shows the new slot-3 word.
- frame_valid and sync_err are never asserted in the same cycle.
- rst mid-frame discards the partial frame; the block must relock via a new sync beat.

Optional Feature:
- Macro: TDM_DEMUX_DOUBLE_BUFFER_EN.
- Defined:
  - Slots 0..2 are captured into internal shadow registers.
  - On the slot-3 capture, all four of out0..out3 load together (slot 3 straight from in); the frame is coherent.
  - out0..out3 change only in the cycle frame_valid=1.
  - Resync and lock loss discard the shadow contents; outputs keep the last complete frame.
  - Reset clears the shadows to 0.
- Not defined:
  - Each outN updates individually at its own capture (no shadow registers).
  - Partial-frame words remain visible after a resync or lock loss.

Test Plan:
- Reset/hold: rst=1 for 2 cycles with in=1, in_valid=1, sync=1 -> all outputs 0, locked=0, {sel1,sel0}=00 throughout; no capture.
- Clean frame (WIDTH=1): beats (in,sync) = (1,1),(0,0),(1,0),(1,0), in_valid=1 continuously -> after the 4th edge: out0..out3=1,0,1,1, frame_valid pulses exactly 1 cycle, locked=1, {sel1,sel0}=00.
- Gapped frame: same frame with in_valid=0 for 3 cycles between slots 1 and 2 -> {sel1,sel0} holds at 10 during the gap; identical final outputs; one frame_valid pulse.
- Early sync: lock, send slot0 and slot1, then a sync=1 beat with in=1 -> sync_err 1-cycle pulse, out0=1, {sel1,sel0}=01, locked stays 1, no frame_valid.
- Missing sync: after a complete frame, send in_valid=1, sync=0 -> sync_err pulse, locked=0 next cycle, out0 unchanged. Three further non-sync beats are ignored until the next sync=1.
- DOUBLE_BUFFER_EN build: during the clean-frame test, out0..out2 stay at the previous frame until the slot-3 edge, then all four update together with frame_valid=1. In the non-macro build, out0 updates one cycle after the slot-0 beat.
